rr_arbiter_16: RTL and testbench

- 16-requester round-robin arbiter for one shared resource.
- Registers a 4-bit winner index and expands it to a one-hot grant vector through a 4-to-16 index decoder.
- Sits between 16 client blocks and the shared resource; grants are held until the owner releases them.
- Fairness: the most recently served requester has the lowest priority on the next arbitration.

---
 rtl/rr_arbiter_16_pkg.sv | 18 +
 rtl/rr_arbiter_16_if.sv | 30 +++
 rtl/rr_arbiter_16_idx_onehot16.sv | 11 +
 rtl/rr_arbiter_16.sv | 136 +++++++++++++
 tb/tb_rr_arbiter_16.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_16_pkg.sv
// Shared constants, FSM encoding and winner-search result type for the 16-way round-robin arbiter.
package rr_arbiter_16_pkg;

  localparam int N_REQ        = 16;
  localparam int IDX_W        = 4;
  localparam int MAX_HOLD_DEF = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } win_t;

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the 16 clients (master) and the arbiter (slave).
interface rr_arbiter_16_if;
  import rr_arbiter_16_pkg::*;

  logic [N_REQ-1:0] req;
  logic             rel;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req,
    output rel,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  rel,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter_16_idx_onehot16.sv
// 4-bit index to 16-bit one-hot expander; purely combinational, zero latency, no flow control.
module idx_onehot16
  import rr_arbiter_16_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  assign onehot = N_REQ'(1) << idx;

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter: grant one cycle after req, held until rel or abandon, back-to-back handover.
// Define ARB_TIMEOUT_EN to revoke any grant after MAX_HOLD cycles and pulse timeout.
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_16_if.slave arb
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [N_REQ-1:0] owner_oh;
  logic             owner_req;
  logic             hold_expired;
  logic             end_grant;
  logic [IDX_W-1:0] search_base;
  logic [N_REQ-1:0] search_req;
  win_t             win;

  // Cyclic search: offset 0 (base) is highest priority, so scan downwards and let lower offsets overwrite.
  function automatic win_t find_winner(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] base);
    win_t             w;
    logic [IDX_W-1:0] cand;
    w.found = 1'b0;
    w.idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = base + IDX_W'(k);
      if (r[cand]) begin
        w.found = 1'b1;
        w.idx   = cand;
      end
    end
    return w;
  endfunction

  idx_onehot16 u_idx_onehot16 (
    .idx    (idx_q),
    .onehot (owner_oh)
  );

  assign owner_req = arb.req[idx_q];
  assign end_grant = (state == ST_BUSY) && (arb.rel || !owner_req || hold_expired);

  // While busy the search already uses the post-release pointer and masks out the current owner.
  always_comb begin
    search_base = ptr;
    search_req  = arb.req;
    if (state == ST_BUSY) begin
      search_base = idx_q + IDX_W'(1);
      search_req  = arb.req & ~owner_oh;
    end
  end

  assign win = find_winner(search_req, search_base);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx_q;
    case (state)
      ST_IDLE: begin
        if (win.found) begin
          state_nxt = ST_BUSY;
          idx_nxt   = win.idx;
        end
      end
      ST_BUSY: begin
        if (end_grant) begin
          ptr_nxt = search_base;
          if (win.found) begin
            idx_nxt = win.idx;
          end else begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx_q <= idx_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  assign hold_expired = (state == ST_BUSY) && (hold_cnt == HOLD_LAST);
  assign arb.timeout  = hold_expired && !arb.rel && owner_req;

  // Counter restarts on every new grant, including a same-cycle handover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == ST_BUSY && !end_grant) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  // Without the hold counter MAX_HOLD has no effect; grants are unbounded either way.
  if (MAX_HOLD >= 1 && MAX_HOLD <= 255) begin : g_no_timeout
    assign hold_expired = 1'b0;
  end else begin : g_no_timeout_odd_hold
    assign hold_expired = 1'b0;
  end
  assign arb.timeout = 1'b0;
`endif

  assign arb.grant       = owner_oh & {N_REQ{state == ST_BUSY}};
  assign arb.grant_idx   = idx_q;
  assign arb.grant_valid = (state == ST_BUSY);

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(arb.grant));
  a_idle_idx_zero : assert property (@(posedge clk) disable iff (!rst_n)
                                     !arb.grant_valid |-> (arb.grant_idx == '0));

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: rotation, wrap, exclusion, abandon, async reset, hold limit.
module tb_rr_arbiter_16;
  import rr_arbiter_16_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [21:0] got;
  logic [21:0] exp;

  rr_arbiter_16_if arb ();

  rr_arbiter_16 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {grant[15:0], grant_idx[3:0], grant_valid, timeout}.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    arb.req = '0;
    arb.rel = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    arb.req = '0;
    arb.rel = 1'b0;
    #1;
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", got, exp);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL idle_no_req cycle %0d: got %h want %h", c, got, exp);
      end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    arb.req = 16'h0011;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rot_first: got %h want %h", got, exp);
    end
    arb.rel = 1'b1;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0010, 4'd4, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rot_second: got %h want %h", got, exp);
    end
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rot_back: got %h want %h", got, exp);
    end
    arb.rel = 1'b0;
    arb.req = 16'h0000;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rot_to_idle: got %h want %h", got, exp);
    end
  endtask

  task automatic test_wrap();
    arb.req = 16'h8000;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h8000, 4'd15, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL wrap_owner15: got %h want %h", got, exp);
    end
    arb.req = 16'h8004;
    arb.rel = 1'b1;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0004, 4'd2, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL wrap_next: got %h want %h", got, exp);
    end
    arb.req = 16'h0000;
    arb.rel = 1'b0;
    step();
  endtask

  task automatic test_single_rerequest();
    arb.req = 16'h0200;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0200, 4'd9, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL single_grant: got %h want %h", got, exp);
    end
    arb.rel = 1'b1;
    step();
    arb.rel = 1'b0;
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL single_gap: got %h want %h", got, exp);
    end
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0200, 4'd9, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL single_regrant: got %h want %h", got, exp);
    end
    arb.req = 16'h0000;
    step();
  endtask

  task automatic test_rel_idle();
    arb.rel = 1'b1;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rel_idle_stays: got %h want %h", got, exp);
    end
    arb.req = 16'h0040;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0040, 4'd6, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rel_idle_ignored: got %h want %h", got, exp);
    end
    arb.rel = 1'b0;
    arb.req = 16'h0000;
    step();
  endtask

  task automatic test_abandon_and_reset();
    arb.req = 16'h0008;
    step();
    arb.req = 16'h0009;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0008, 4'd3, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL no_preempt: got %h want %h", got, exp);
    end
    arb.req = 16'h0081;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0080, 4'd7, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL abandon_next: got %h want %h", got, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", got, exp);
    end
    #2;
    arb.req = 16'h8001;
    rst_n   = 1'b1;
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL ptr_after_reset: got %h want %h", got, exp);
    end
  endtask

  task automatic test_hold_limit();
    do_reset();
    arb.req = 16'h0003;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step();
      got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
      exp = {16'h0001, 4'd0, 1'b1, (c == 3)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL hold_cycle %0d: got %h want %h", c, got, exp);
      end
    end
    step();
    got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
    exp = {16'h0002, 4'd1, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL hold_handover: got %h want %h", got, exp);
    end
`else
    for (int c = 0; c < 20; c++) begin
      step();
      got = {arb.grant, arb.grant_idx, arb.grant_valid, arb.timeout};
      exp = {16'h0001, 4'd0, 1'b1, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL hold_unbounded cycle %0d: got %h want %h", c, got, exp);
      end
    end
`endif
    arb.req = 16'h0000;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rotation();
    test_wrap();
    test_single_rerequest();
    test_rel_idle();
    test_abandon_and_reset();
    test_hold_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
